// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: in-order writeback (A) vs buffered long-latency results (B),
// with a starvation guard for B and a pending-destination scoreboard driving the decode stall.
module regfile_write_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        a_valid,
  input  logic [4:0]  a_sel,
  input  logic [31:0] a_dat,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_sel,
  input  logic [31:0] b_dat,
  output logic        b_ready,
  input  logic        pend_set,
  input  logic [4:0]  pend_sel,
  input  logic [4:0]  rsel1,
  input  logic [4:0]  rsel2,
  output logic        stall,
  output logic        busy,
  output logic        WEN,
  output logic [4:0]  wsel,
  output logic [31:0] wdat
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]    sel_mem [DEPTH];
  logic [31:0]   dat_mem [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   pend_q, pend_d;

  logic not_empty, override, push, pop;
  logic [4:0] head_sel;
  logic [31:0] head_dat;

  assign head_sel  = sel_mem[rd_q];
  assign head_dat  = dat_mem[rd_q];
  assign not_empty = (count_q != '0);
  assign override  = not_empty && (starve_q == SW'(STARVE_MAX));

  assign b_ready = !nRST && (count_q < CW'(DEPTH));
  assign busy    = !nRST && not_empty;
  assign stall   = !nRST && (pend_q[rsel1] || pend_q[rsel2]);
  assign push    = b_valid && b_ready && (b_sel != 5'd0);

  always_comb begin
    a_ready = 1'b0;
    WEN     = 1'b0;
    wsel    = 5'd0;
    wdat    = 32'd0;
    pop     = 1'b0;
    if (!nRST) begin
      if (override) begin
        pop = 1'b1;
      end else if (a_valid && (a_sel != 5'd0)) begin
        a_ready = 1'b1;
        WEN     = 1'b1;
        wsel    = a_sel;
        wdat    = a_dat;
      end else begin
        // a write to r0 is consumed without using the port, so the head may take it
        a_ready = a_valid;
        pop     = not_empty;
      end
      if (pop) begin
        WEN  = 1'b1;
        wsel = head_sel;
        wdat = head_dat;
      end
    end
  end

  always_comb begin
    rd_d     = pop  ? rd_q + AW'(1) : rd_q;
    wr_d     = push ? wr_q + AW'(1) : wr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
    starve_d = starve_q;
    if (!not_empty || pop)
      starve_d = '0;
    else if (starve_q != SW'(STARVE_MAX))
      starve_d = starve_q + SW'(1);
    pend_d = pend_q;
    if (pop) pend_d[head_sel] = 1'b0;
    // set after clear so a same-cycle reissue to the same register stays pending
    if (pend_set && (pend_sel != 5'd0)) pend_d[pend_sel] = 1'b1;
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      rd_q     <= '0;
      wr_q     <= '0;
      count_q  <= '0;
      starve_q <= '0;
      pend_q   <= '0;
    end else begin
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      pend_q   <= pend_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      sel_mem[wr_q] <= b_sel;
      dat_mem[wr_q] <= b_dat;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_regfile_write_arbiter;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic CLK = 1'b0;
  logic nRST;
  logic a_valid, b_valid, pend_set;
  logic [4:0] a_sel, b_sel, pend_sel, rsel1, rsel2;
  logic [31:0] a_dat, b_dat;
  logic a_ready, b_ready, stall, busy, WEN;
  logic [4:0] wsel;
  logic [31:0] wdat;

  always #5 CLK = ~CLK;

  regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .nRST(nRST),
    .a_valid(a_valid), .a_sel(a_sel), .a_dat(a_dat), .a_ready(a_ready),
    .b_valid(b_valid), .b_sel(b_sel), .b_dat(b_dat), .b_ready(b_ready),
    .pend_set(pend_set), .pend_sel(pend_sel), .rsel1(rsel1), .rsel2(rsel2),
    .stall(stall), .busy(busy), .WEN(WEN), .wsel(wsel), .wdat(wdat)
  );

  typedef struct packed {logic [4:0] sel; logic [31:0] dat;} ent_t;
  ent_t q[$];
  int starve;
  bit [31:0] pend;
  int n_tests = 0, n_fail = 0;
  logic s_wen, s_aready, s_bready, s_stall, s_busy;
  logic [4:0] s_wsel;
  logic [31:0] s_wdat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    a_valid = 0; a_sel = 0; a_dat = 0;
    b_valid = 0; b_sel = 0; b_dat = 0;
    pend_set = 0; pend_sel = 0; rsel1 = 0; rsel2 = 0;
  endtask

  // One clock cycle: inputs already driven; check at negedge, update model, return at posedge+1.
  task automatic step();
    logic e_wen, e_ar, e_br, e_stall, e_busy;
    logic [4:0] e_ws;
    logic [31:0] e_wd;
    bit do_pop;
    ent_t e;
    @(negedge CLK);
    e_wen = 0; e_ar = 0; e_br = 0; e_stall = 0; e_busy = 0; e_ws = 0; e_wd = 0; do_pop = 0;
    if (nRST) begin
      q.delete(); starve = 0; pend = 0;
    end else begin
      e_br    = (q.size() < DEPTH);
      e_busy  = (q.size() != 0);
      e_stall = pend[rsel1] | pend[rsel2];
      if (q.size() != 0 && starve == SMAX) do_pop = 1;
      else if (a_valid && a_sel != 0) begin
        e_ar = 1; e_wen = 1; e_ws = a_sel; e_wd = a_dat;
      end else begin
        e_ar = a_valid;
        do_pop = (q.size() != 0);
      end
      if (do_pop) begin
        e_wen = 1; e_ws = q[0].sel; e_wd = q[0].dat;
      end
    end
    chk("a_ready", a_ready, e_ar);
    chk("b_ready", b_ready, e_br);
    chk("WEN", WEN, e_wen);
    chk("wsel", wsel, e_ws);
    chk("wdat", wdat, e_wd);
    chk("stall", stall, e_stall);
    chk("busy", busy, e_busy);
    s_wen = WEN; s_wsel = wsel; s_wdat = wdat; s_aready = a_ready;
    s_bready = b_ready; s_stall = stall; s_busy = busy;
    if (!nRST) begin
      if (do_pop) begin
        e = q.pop_front();
        pend[e.sel] = 0;
        starve = 0;
      end else if (q.size() == 0) starve = 0;
      else if (starve < SMAX) starve++;
      if (pend_set && pend_sel != 0) pend[pend_sel] = 1;
      if (b_valid && e_br && b_sel != 0) q.push_back('{b_sel, b_dat});
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    idle();
    nRST = 1;
    starve = 0; pend = 0;
    #1;
    chk("rst_WEN", WEN, 0);
    chk("rst_b_ready", b_ready, 0);
    step();
    nRST = 0;
    @(posedge CLK); #1;

    // idle path: single B result written the following cycle
    b_valid = 1; b_sel = 5; b_dat = 32'hDEADBEEF;
    step();
    chk("idle_bready", s_bready, 1);
    idle(); step();
    chk("idle_wen", s_wen, 1);
    chk("idle_wsel", s_wsel, 5);
    chk("idle_wdat", s_wdat, 32'hDEADBEEF);
    step();
    chk("idle_busy", s_busy, 0);

    // starvation guard
    a_valid = 1; a_sel = 3; a_dat = 32'h1111;
    b_valid = 1; b_sel = 7; b_dat = 32'h7777;
    step();
    b_valid = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("starve_wsel", s_wsel, (i == 5) ? 5'd7 : 5'd3);
      chk("starve_aready", s_aready, (i == 5) ? 1'b0 : 1'b1);
    end

    // full FIFO with A saturated
    b_valid = 1; b_sel = 10; b_dat = 32'hA0; step();
    b_sel = 11; b_dat = 32'hA1; step();
    b_sel = 12; b_dat = 32'hA2; step();
    chk("full_bready", s_bready, 0);
    b_valid = 0;
    for (int i = 0; i < 12; i++) step();

    // scoreboard: same-cycle set and pop of r9 keeps it pending
    idle();
    pend_set = 1; pend_sel = 9; b_valid = 1; b_sel = 9; b_dat = 32'h99;
    step();
    b_valid = 0; rsel1 = 9;
    step();
    chk("sb_wsel", s_wsel, 9);
    pend_set = 0;
    step();
    chk("sb_stall_kept", s_stall, 1);
    b_valid = 1; b_sel = 9; b_dat = 32'h98; step();
    b_valid = 0; step();
    step();
    chk("sb_stall_clr", s_stall, 0);

    // zero register paths
    idle();
    a_valid = 1; a_sel = 3; b_valid = 1; b_sel = 4; b_dat = 32'h44; step();
    b_valid = 0; a_sel = 0; step();
    chk("zero_aready", s_aready, 1);
    chk("zero_wsel", s_wsel, 4);
    idle(); b_valid = 1; b_sel = 0; b_dat = 32'h55; step();
    chk("zero_b_ready", s_bready, 1);
    idle(); step();
    chk("zero_nowrite", s_wen, 0);
    chk("zero_busy", s_busy, 0);

    // reset mid-operation
    a_valid = 1; a_sel = 3; pend_set = 1; pend_sel = 9;
    b_valid = 1; b_sel = 14; b_dat = 32'hE0; step();
    pend_set = 0; b_sel = 15; b_dat = 32'hF0; step();
    b_valid = 0; rsel1 = 9;
    nRST = 1; #1;
    chk("midrst_WEN", WEN, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_stall", stall, 0);
    step();
    nRST = 0;
    idle(); rsel1 = 9;
    for (int i = 0; i < 4; i++) step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int heavy;
      heavy    = ((i / 200) % 2 == 1) ? 95 : 50;
      a_valid  = ($urandom_range(0, 99) < heavy);
      a_sel    = 5'($urandom_range(0, 15));
      a_dat    = $urandom;
      b_valid  = ($urandom_range(0, 99) < 40);
      b_sel    = 5'($urandom_range(0, 15));
      b_dat    = $urandom;
      pend_set = ($urandom_range(0, 99) < 30);
      pend_sel = 5'($urandom_range(0, 15));
      rsel1    = 5'($urandom_range(0, 15));
      rsel2    = 5'($urandom_range(0, 15));
      if (i % 997 == 500) nRST = 1;
      else nRST = 0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Arbitrates the register file's single write port between the in-order pipeline writeback (port A) and a long-latency unit such as mult/div or a miss-handling load path (port B). Port B results are buffered in a small FIFO, and a starvation guard ensures they drain. A 32-entry pending scoreboard tracks destinations owned by port B and raises a read-stall for the decode stage. The block sits directly in front of the register file write port (WEN/wsel/wdat).

## Interface
- DEPTH, 2, port-B FIFO entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive lost cycles before the FIFO head overrides port A (≥1)
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-high
- a_valid  in  1  pipeline writeback request
- a_sel  in  5  pipeline destination register
- a_dat  in  32  pipeline write data
- a_ready  out  1  port A request consumed this cycle
- b_valid  in  1  long-latency result valid
- b_sel  in  5  long-latency destination register
- b_dat  in  32  long-latency write data
- b_ready  out  1  FIFO can accept this cycle
- pend_set  in  1  issue of a port-B op; mark pend_sel pending
- pend_sel  in  5  destination of issued port-B op
- rsel1, rsel2  in  5 each  decode read selects
- stall  out  1  a read select is pending
- busy  out  1  FIFO non-empty
- WEN  out  1  register file write enable
- wsel  out  5  register file write select
- wdat  out  32  register file write data

## Operation
- State: FIFO (DEPTH × {sel, dat}), rd/wr pointers plus count, starve_cnt of width clog2(STARVE_MAX+1), pending[31:0].
- Reset (nRST high): FIFO empty, starve_cnt=0, pending=0. Outputs WEN=0, wsel=0, wdat=0, a_ready=0, b_ready=0, stall=0, busy=0.
- Enqueue: b_ready = (count < DEPTH), computed from registered state only. b_valid & b_ready pushes {b_sel, b_dat}. If b_sel==0, the request is accepted but not pushed.
- Override condition: override = (count≠0) & (starve_cnt == STARVE_MAX).
- Grant, evaluated every cycle in priority order:
  1. Override: FIFO head drives the write port and is popped. a_ready=0; port A holds its request.
  2. a_valid & a_sel≠0: A drives the write port, a_ready=1.
  3. a_valid & a_sel==0: a_ready=1, no write. The FIFO head may take the port in the same cycle.
  4. FIFO non-empty: head drives the write port and is popped.
  5. Otherwise WEN=0, wsel=0, wdat=0.
- starve_cnt:
  - Cleared to 0 when the FIFO is empty or the head is popped.
  - Incremented when the FIFO is non-empty and port A wins.
  - Saturates at STARVE_MAX.
- Scoreboard:
  - pend_set with pend_sel≠0 sets pending[pend_sel].
  - A FIFO pop with head.sel=s clears pending[s].
  - If set and clear target the same register in the same cycle, set wins.
  - pending[0] is never set.
- stall = pending[rsel1] | pending[rsel2]. Combinational; bit 0 reads as 0.
- busy = (count≠0).
- Port A writes to a pending register are a pipeline protocol error. The block still performs writes strictly in grant order.

## Timing
- Write port outputs are combinational from a_* and the FIFO head. The register file captures them at the next rising edge.
- Port A: zero added latency when granted.
- Port B: no bypass. A result accepted at edge N can appear on the write port no earlier than the cycle after edge N.
- FIFO push and pop occur at the same edge and count updates accordingly. When full, b_ready=0, so a push can never coincide with a full FIFO.
- Pending-bit clear takes effect at the pop edge; stall drops in the following cycle.
- With port A saturated, a FIFO head waits at most STARVE_MAX cycles and is written in cycle STARVE_MAX+1.
- Reset mid-operation: FIFO contents and pending bits are discarded immediately (asynchronous); no write is issued after reset asserts.

## Test plan
- Idle: b_valid with b_sel=5, b_dat=0xDEADBEEF, no port-A traffic -> b_ready=1; the next cycle shows WEN=1, wsel=5, wdat=0xDEADBEEF; busy returns to 0.
- Starvation: FIFO holds sel=7 while a_valid=1 (sel=3) every cycle, STARVE_MAX=4 -> A wins 4 cycles; cycle 5 shows a_ready=0, wsel=7; A wins again in cycle 6.
- Full FIFO: 3 back-to-back B pushes with DEPTH=2 and A saturated -> b_ready=0 after the 2nd push; the 3rd push is accepted only after a pop; entries are written in FIFO order.
- Scoreboard: pend_set with sel=9, then rsel1=9 -> stall=1 until the FIFO writes sel=9; stall=0 the cycle after that pop. Same-cycle pend_set(9) and pop(9) -> pending[9] stays 1.
- Zero register: a_valid with a_sel=0 and FIFO head sel=4 -> a_ready=1, WEN=1, wsel=4. b_valid with b_sel=0 -> accepted, no write, busy unchanged.
- Reset mid-operation: assert nRST with 2 entries queued and pending=0x200 -> WEN=0, busy=0, stall=0 immediately; after release, no stale writes appear.
